pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline. It drives stall, flush and forwarding controls into the F/D/E/M/W pipeline registers. It owns a small FSM that freezes the pipeline while a variable-latency data memory completes a MEM-stage access, and it flags a timeout. It also keeps a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for mem_ack before the error state is entered (must be ≥2)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_d, rs2_d  in  5  source regs of instruction in D
rs1_e, rs2_e, rd_e  in  5  source/dest regs of instruction in E
res_src_e  in  2  result source in E (00 alu, 01 mem, 10 pc+4, 11 imm)
pc_src_e  in  1  taken branch/jump resolved in E
rd_m, rd_w  in  5  dest regs in M, W
reg_wr_m, reg_wr_w  in  1  regfile write enables in M, W
mem_access_m  in  1  load/store present in M
mem_ack  in  1  data memory completes access this cycle
stall_f, stall_d, stall_e, stall_m  out  1  hold corresponding pipeline register
flush_d, flush_e, flush_w  out  1  load bubble (zero controls, rd=0) into register
fwd_a_e, fwd_b_e  out  2  E operand select: 00 regfile, 01 from W, 10 from M
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with stall_f=1

Behaviour:
- Clock and reset are decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- While rst_n=0: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
- While rst_n=0, outputs are forced: flush_d=flush_e=flush_w=1, all stalls=0, fwd=00.
- After reset deasserts, the pipeline runs from the next rising edge.
- FSM states: RUN, MWAIT, MERR.
- RUN → MWAIT when mem_access_m=1 and mem_ack=0. wait_cnt is set to 1.
- MWAIT → RUN when mem_ack=1.
- MWAIT → MERR when wait_cnt=MEM_TIMEOUT-1 and mem_ack=0.
- MERR is terminal until reset. mem_err=1 in MERR.
- Memory wait (mem_access_m & ~mem_ack in RUN or MWAIT, or any cycle in MERR):
  - stall_f=stall_d=stall_e=stall_m=1 and flush_w=1.
  - flush_d=flush_e=0.
  - Highest priority: it masks load-use and branch actions.
- Memory stalls are combinational. The cycle mem_ack=1 arrives, stalls drop and M advances on that edge.
- Single-cycle memory (ack in the same cycle as access) causes zero stall.
- Load-use (no memory wait): res_src_e=01, rd_e≠0, and rd_e equals rs1_d or rs2_d. Response: stall_f=stall_d=1, flush_e=1. Exactly one bubble.
- Taken branch (no memory wait): pc_src_e=1 gives flush_d=flush_e=1.
  - If load-use is also true in the same cycle, the branch wins: no stall, because the dependent D instruction is squashed.
- Forwarding for fwd_a_e (fwd_b_e is identical using rs2_e):
  - 10 if reg_wr_m, rd_m≠0 and rd_m=rs1_e.
  - Else 01 if reg_wr_w, rd_w≠0 and rd_w=rs1_e.
  - Else 00.
  - M takes priority over W. x0 never forwards.
- Forwarding is combinational and independent of FSM state.
- stall_cnt increments on each clock edge where stall_f=1 and saturates at all-ones.
- All other outputs are combinational from state and inputs.

Decomposition:
- Shared package pipe_pkg holds:
  - RES_SRC_ALU/MEM/PC4/IMM encodings
  - FWD_RF/FWD_W/FWD_M encodings
  - FSM state enum (RUN, MWAIT, MERR)
- One natural sub-module: fwd_unit (pure combinational operand-select logic), instantiated once per operand.
- The FSM, hazard priority and counter stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-MWAIT (wait_cnt=5), hold for 2 cycles → state RUN, flush_d/e/w=1, stall_cnt=0, mem_err=0. Outputs return to normal on release.
- Forwarding: rd_m=5 reg_wr_m=1, rd_w=5 reg_wr_w=1, rs1_e=5 → fwd_a_e=10. Drop reg_wr_m → 01. Set rd_m=rd_w=rs1_e=0 → 00.
- Load-use then branch: res_src_e=01 rd_e=7 rs2_d=7 → one cycle of stall_f=stall_d=1, flush_e=1, and stall_cnt increments by 1. Same stimulus with pc_src_e=1 → flush_d=flush_e=1, stall_f=0.
- Memory wait: mem_access_m=1 with mem_ack arriving on cycle 4 → stalls are high for cycles 1-3 and drop on cycle 4, flush_w is high for cycles 1-3, stall_cnt=3. A coincident pc_src_e=1 gives no flush until the wait ends.
- Timeout: MEM_TIMEOUT=4 and mem_ack held 0 → MERR after 4 wait cycles. mem_err=1 and all stalls stay high. A later mem_ack=1 has no effect; only rst_n clears it.
- Counter saturation: CNT_W=4 with a continuous stall for 20 cycles → stall_cnt stays at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and FSM state type for the RV32I pipeline hazard controller.
package pipe_pkg;

  localparam logic [1:0] RES_SRC_ALU = 2'b00;
  localparam logic [1:0] RES_SRC_MEM = 2'b01;
  localparam logic [1:0] RES_SRC_PC4 = 2'b10;
  localparam logic [1:0] RES_SRC_IMM = 2'b11;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MWAIT = 2'b01,
    MERR  = 2'b10
  } hz_state_t;

  // x0 is hardwired to zero, so it never matches as a producer.
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand bypass select for one E-stage source register; M has priority over W.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_wr_m,
  input  logic       reg_wr_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_wr_m && reg_hit(rd_m, rs_e)) begin
      fwd = FWD_M;
    end else if (reg_wr_w && reg_hit(rd_w, rs_e)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: memory-wait FSM, load-use and branch handling,
// operand forwarding and a saturating stall-cycle counter.
//
// state | meaning
// RUN   | normal flow; a MEM access without ack enters MWAIT
// MWAIT | waiting on data memory ack, wait_cnt counts waited cycles
// MERR  | memory timed out; pipeline frozen until reset
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       res_src_e,
  input  logic             pc_src_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_wr_m,
  input  logic             reg_wr_w,
  input  logic             mem_access_m,
  input  logic             mem_ack,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("pipe_hazard_ctrl: MEM_TIMEOUT must be at least 2");
  end

  hz_state_t       state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            mem_wait;
  logic            load_use;
  logic [1:0]      fwd_a_raw, fwd_b_raw;
  logic [CNT_W-1:0] stall_cnt_q;

  fwd_unit u_fwd_a (
    .rs_e     (rs1_e),
    .rd_m     (rd_m),
    .rd_w     (rd_w),
    .reg_wr_m (reg_wr_m),
    .reg_wr_w (reg_wr_w),
    .fwd      (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .rs_e     (rs2_e),
    .rd_m     (rd_m),
    .rd_w     (rd_w),
    .reg_wr_m (reg_wr_m),
    .reg_wr_w (reg_wr_w),
    .fwd      (fwd_b_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_access_m && !mem_ack) begin
          state_nxt    = MWAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MWAIT: begin
        // Ack is checked first so a response on the last allowed cycle still completes.
        if (mem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = MERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      MERR: begin
        state_nxt = MERR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  assign mem_wait = (state == MERR) ||
                    (((state == RUN) || (state == MWAIT)) && mem_access_m && !mem_ack);

  assign load_use = (res_src_e == RES_SRC_MEM) &&
                    (reg_hit(rd_e, rs1_d) || reg_hit(rd_e, rs2_d));

  // Priority: reset, memory wait, taken branch (squashes the dependent load-use), load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign fwd_a_e = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b_e = rst_n ? fwd_b_raw : FWD_RF;
  assign mem_err = (state == MERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: a default-size instance plus a small one (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] res_src_e;
  logic       pc_src_e, reg_wr_m, reg_wr_w, mem_access_m, mem_ack;

  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [15:0] stall_cnt;

  logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_flush_w, s_mem_err;
  logic [1:0]  s_fwd_a_e, s_fwd_b_e;
  logic [3:0]  s_stall_cnt;

  typedef struct packed {
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_err;
    logic [15:0] cnt;
  } obs_t;

  localparam logic [6:0] SF_IDLE = 7'b0000000;
  localparam logic [6:0] SF_RST  = 7'b0000111;
  localparam logic [6:0] SF_MW   = 7'b1111001;
  localparam logic [6:0] SF_LU   = 7'b1100010;
  localparam logic [6:0] SF_BR   = 7'b0000110;

  obs_t obs_main, obs_small;
  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt_s;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .res_src_e(res_src_e), .pc_src_e(pc_src_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_wr_m(reg_wr_m), .reg_wr_w(reg_wr_w), .mem_access_m(mem_access_m), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .res_src_e(res_src_e), .pc_src_e(pc_src_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_wr_m(reg_wr_m), .reg_wr_w(reg_wr_w), .mem_access_m(mem_access_m), .mem_ack(mem_ack),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .flush_w(s_flush_w),
    .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt)
  );

  assign obs_main  = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                      fwd_a_e, fwd_b_e, mem_err, stall_cnt};
  assign obs_small = {s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_flush_w,
                      s_fwd_a_e, s_fwd_b_e, s_mem_err, 12'd0, s_stall_cnt};

  function automatic obs_t mk(input logic [6:0] sf, input logic [1:0] fa, input logic [1:0] fb,
                              input logic err, input logic [15:0] cnt);
    mk = {sf, fa, fb, err, cnt};
  endfunction

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    res_src_e = 2'b00; pc_src_e = 0; reg_wr_m = 0; reg_wr_w = 0;
    mem_access_m = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_cnt_s = 0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    idle();
    rst_n = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(SF_RST, 2'b00, 2'b00, 1'b0, 16'd0));
      @(negedge clk);
      g = obs_main; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_init cyc%0d got %h want %h", i, g, e); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    mem_access_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(SF_MW, 2'b00, 2'b00, 1'b0, exp_cnt));
      @(negedge clk);
      g = obs_main; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_prewait cyc%0d got %h want %h", i, g, e); end
      exp_cnt++;
      @(posedge clk); #1;
    end
    // wait_cnt is now 5; reset lands mid-wait with a forwardable operand present
    rs1_e = 5; rd_m = 5; reg_wr_m = 1'b1;
    rst_n = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(SF_RST, 2'b00, 2'b00, 1'b0, 16'd0));
      @(negedge clk);
      g = obs_main; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_midwait cyc%0d got %h want %h", i, g, e); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    mem_ack = 1'b1;
    exp_q.push_back(mk(SF_IDLE, 2'b10, 2'b00, 1'b0, 16'd0));
    @(negedge clk);
    g = obs_main; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_release got %h want %h", g, e); end
    @(posedge clk); #1;
    idle();
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rdm, rdw;
    logic       wm, ww;
    logic [1:0] fa, fb;
  } fwd_row_t;

  task automatic test_forwarding();
    obs_t e, g;
    fwd_row_t t [7] = '{
      '{5'd5,  5'd0,  5'd5,  5'd5,  1'b1, 1'b1, 2'b10, 2'b00},
      '{5'd5,  5'd0,  5'd5,  5'd5,  1'b0, 1'b1, 2'b01, 2'b00},
      '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00},
      '{5'd5,  5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 2'b10, 2'b10},
      '{5'd3,  5'd4,  5'd4,  5'd3,  1'b1, 1'b1, 2'b01, 2'b10},
      '{5'd3,  5'd4,  5'd3,  5'd4,  1'b0, 1'b0, 2'b00, 2'b00},
      '{5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1, 2'b01, 2'b01}
    };
    for (int i = 0; i < 7; i++) begin
      rs1_e = t[i].rs1; rs2_e = t[i].rs2; rd_m = t[i].rdm; rd_w = t[i].rdw;
      reg_wr_m = t[i].wm; reg_wr_w = t[i].ww;
      exp_q.push_back(mk(SF_IDLE, t[i].fa, t[i].fb, 1'b0, exp_cnt));
      @(negedge clk);
      g = obs_main; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL fwd row%0d got %h want %h", i, g, e); end
      @(posedge clk); #1;
    end
    idle();
  endtask

  typedef struct {
    logic [1:0] rs;
    logic [4:0] rde, r1, r2;
    logic       br;
    logic [6:0] sf;
  } lu_row_t;

  task automatic test_load_use();
    obs_t e, g;
    lu_row_t t [9] = '{
      '{2'b01, 5'd7, 5'd0, 5'd7, 1'b0, SF_LU},
      '{2'b00, 5'd0, 5'd0, 5'd7, 1'b0, SF_IDLE},
      '{2'b01, 5'd7, 5'd7, 5'd0, 1'b0, SF_LU},
      '{2'b01, 5'd0, 5'd0, 5'd0, 1'b0, SF_IDLE},
      '{2'b00, 5'd7, 5'd7, 5'd7, 1'b0, SF_IDLE},
      '{2'b10, 5'd7, 5'd7, 5'd7, 1'b0, SF_IDLE},
      '{2'b01, 5'd7, 5'd0, 5'd7, 1'b1, SF_BR},
      '{2'b00, 5'd0, 5'd0, 5'd0, 1'b1, SF_BR},
      '{2'b01, 5'd7, 5'd3, 5'd4, 1'b0, SF_IDLE}
    };
    for (int i = 0; i < 9; i++) begin
      res_src_e = t[i].rs; rd_e = t[i].rde; rs1_d = t[i].r1; rs2_d = t[i].r2; pc_src_e = t[i].br;
      exp_q.push_back(mk(t[i].sf, 2'b00, 2'b00, 1'b0, exp_cnt));
      @(negedge clk);
      g = obs_main; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL load_use row%0d got %h want %h", i, g, e); end
      if (e.stall_f && exp_cnt != 16'hFFFF) exp_cnt++;
      @(posedge clk); #1;
    end
    idle();
  endtask

  typedef struct {
    logic       acc, ack, br, lu;
    logic [6:0] sf;
  } mw_row_t;

  task automatic test_mem_wait();
    obs_t e, g;
    mw_row_t t [12] = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, SF_MW},
      '{1'b1, 1'b0, 1'b0, 1'b0, SF_MW},
      '{1'b1, 1'b0, 1'b0, 1'b0, SF_MW},
      '{1'b1, 1'b1, 1'b0, 1'b0, SF_IDLE},
      '{1'b0, 1'b0, 1'b0, 1'b0, SF_IDLE},
      '{1'b1, 1'b0, 1'b1, 1'b0, SF_MW},
      '{1'b1, 1'b0, 1'b1, 1'b0, SF_MW},
      '{1'b1, 1'b0, 1'b1, 1'b1, SF_MW},
      '{1'b1, 1'b1, 1'b1, 1'b0, SF_BR},
      '{1'b1, 1'b1, 1'b0, 1'b0, SF_IDLE},
      '{1'b0, 1'b0, 1'b0, 1'b1, SF_LU},
      '{1'b0, 1'b0, 1'b0, 1'b0, SF_IDLE}
    };
    logic [15:0] cnt_start = exp_cnt;
    for (int i = 0; i < 12; i++) begin
      mem_access_m = t[i].acc; mem_ack = t[i].ack; pc_src_e = t[i].br;
      res_src_e = t[i].lu ? 2'b01 : 2'b00; rd_e = t[i].lu ? 5'd7 : 5'd0; rs2_d = 5'd7;
      exp_q.push_back(mk(t[i].sf, 2'b00, 2'b00, 1'b0, exp_cnt));
      @(negedge clk);
      g = obs_main; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL mem_wait row%0d got %h want %h", i, g, e); end
      if (e.stall_f && exp_cnt != 16'hFFFF) exp_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== cnt_start + 16'd7) begin
      errors++; $display("FAIL mem_wait_cnt got %0d want %0d", stall_cnt, cnt_start + 16'd7);
    end
    idle();
  endtask

  task automatic test_timeout();
    obs_t e, g;
    logic [6:0] sf;
    logic       err;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      // cycles 0-3 are the allowed wait, 4+ are MERR; ack arrives late at 7
      mem_access_m = (i < 9);
      mem_ack      = (i >= 7);
      sf  = SF_MW;
      err = (i >= 4);
      exp_q.push_back(mk(sf, 2'b00, 2'b00, err, {12'd0, exp_cnt_s}));
      @(negedge clk);
      g = obs_small; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL timeout cyc%0d got %h want %h", i, g, e); end
      if (e.stall_f && exp_cnt_s != 4'hF) exp_cnt_s++;
      @(posedge clk); #1;
    end
    idle();
    rst_n = 1'b0;
    exp_cnt_s = 0;
    exp_q.push_back(mk(SF_RST, 2'b00, 2'b00, 1'b0, 16'd0));
    @(negedge clk);
    g = obs_small; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL timeout_reset got %h want %h", g, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(SF_IDLE, 2'b00, 2'b00, 1'b0, 16'd0));
    @(negedge clk);
    g = obs_small; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL timeout_cleared got %h want %h", g, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    obs_t e, g;
    do_reset();
    mem_access_m = 1'b1;
    for (int i = 0; i < 21; i++) begin
      exp_q.push_back(mk(SF_MW, 2'b00, 2'b00, (i >= 4), {12'd0, exp_cnt_s}));
      @(negedge clk);
      g = obs_small; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL saturate cyc%0d got %h want %h", i, g, e); end
      if (e.stall_f && exp_cnt_s != 4'hF) exp_cnt_s++;
      @(posedge clk); #1;
    end
    checks++;
    if (s_stall_cnt !== 4'd15) begin
      errors++; $display("FAIL saturate_final got %0d want 15", s_stall_cnt);
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
